// File: rtl/ppi_strobed_port.sv
// One WIDTH-bit 8255-style PPI port: mode 0 latched I/O and mode 1 strobed
// I/O with STB/IBF/INTR (input) and OBF/ACK/INTR (output) handshakes.
module ppi_strobed_port #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             port_en,
    input  logic             cfg_wr,
    input  logic             cfg_mode,
    input  logic             cfg_dir,
    input  logic             inte_wr,
    input  logic             inte_val,
    input  logic             cpu_wr,
    input  logic [WIDTH-1:0] cpu_wdata,
    input  logic             cpu_rd,
    output logic [WIDTH-1:0] cpu_rdata,
    input  logic [WIDTH-1:0] port_in,
    output logic [WIDTH-1:0] port_out,
    output logic             port_oe,
    input  logic             stb_n,
    input  logic             ack_n,
    output logic             ibf,
    output logic             obf_n,
    output logic             intr,
    output logic             overrun
);

    logic             mode;
    logic             dir;
    logic             inte;
    logic [WIDTH-1:0] out_latch;
    logic [WIDTH-1:0] in_latch;
    logic             stb_h1, stb_h2;
    logic             ack_h1, ack_h2;
    logic             stb_fall, stb_rise, ack_fall, ack_rise;
    logic             wr_ok, rd_ok;
    logic [WIDTH-1:0] rd_mux;

    // Two-deep history: strobes are synchronised before edge detection.
    assign stb_fall = stb_h2 & ~stb_h1;
    assign stb_rise = ~stb_h2 & stb_h1;
    assign ack_fall = ack_h2 & ~ack_h1;
    assign ack_rise = ~ack_h2 & ack_h1;

    assign wr_ok    = cpu_wr & port_en;
    assign rd_ok    = cpu_rd & port_en;
    assign port_out = out_latch;

    always_comb begin
        rd_mux = out_latch;
        if (dir)
            rd_mux = mode ? in_latch : port_in;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mode      <= 1'b0;
            dir       <= 1'b1;
            inte      <= 1'b0;
            out_latch <= '0;
            in_latch  <= '0;
            cpu_rdata <= '0;
            port_oe   <= 1'b0;
            ibf       <= 1'b0;
            obf_n     <= 1'b1;
            intr      <= 1'b0;
            overrun   <= 1'b0;
            stb_h1    <= 1'b1;
            stb_h2    <= 1'b1;
            ack_h1    <= 1'b1;
            ack_h2    <= 1'b1;
        end else begin
            // History always tracks pins so a mode change never sees a stale edge.
            stb_h1 <= stb_n;
            stb_h2 <= stb_h1;
            ack_h1 <= ack_n;
            ack_h2 <= ack_h1;

            if (cfg_wr) begin
                mode      <= cfg_mode;
                dir       <= cfg_dir;
                out_latch <= '0;
                ibf       <= 1'b0;
                obf_n     <= 1'b1;
                intr      <= 1'b0;
                inte      <= 1'b0;
                overrun   <= 1'b0;
                port_oe   <= port_en & ~cfg_dir;
            end else begin
                port_oe <= port_en & ~dir;
                if (inte_wr)
                    inte <= inte_val;
                if (rd_ok)
                    cpu_rdata <= rd_mux;

                if (!mode) begin
                    if (wr_ok && !dir)
                        out_latch <= cpu_wdata;
                end else if (dir) begin
                    if (stb_rise && inte && ibf)
                        intr <= 1'b1;
                    if (rd_ok) begin
                        ibf  <= 1'b0;
                        intr <= 1'b0;
                    end
                    // A new strobe outranks a coincident read.
                    if (stb_fall) begin
                        in_latch <= port_in;
                        ibf      <= 1'b1;
                        intr     <= 1'b0;
                        if (ibf)
                            overrun <= 1'b1;
                    end
                end else begin
                    if (ack_fall)
                        obf_n <= 1'b1;
                    if (ack_rise && inte && obf_n)
                        intr <= 1'b1;
                    // A write outranks a coincident acknowledge.
                    if (wr_ok) begin
                        out_latch <= cpu_wdata;
                        obf_n     <= 1'b0;
                        intr      <= 1'b0;
                        if (!obf_n)
                            overrun <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ppi_strobed_port.sv
// Directed bench for ppi_strobed_port: reset, mode 0 I/O, mode 1 handshakes,
// overrun, coincident-event priority and reconfiguration mid-transfer.
module tb_ppi_strobed_port;

    logic       clk = 1'b0;
    logic       reset, port_en, cfg_wr, cfg_mode, cfg_dir, inte_wr, inte_val;
    logic       cpu_wr, cpu_rd, stb_n, ack_n;
    logic [7:0] cpu_wdata, port_in, cpu_rdata, port_out;
    logic       port_oe, ibf, obf_n, intr, overrun;

    int vectors = 0;
    int miscompares = 0;

    ppi_strobed_port #(.WIDTH(8)) dut (
        .clk(clk), .reset(reset), .port_en(port_en), .cfg_wr(cfg_wr),
        .cfg_mode(cfg_mode), .cfg_dir(cfg_dir), .inte_wr(inte_wr),
        .inte_val(inte_val), .cpu_wr(cpu_wr), .cpu_wdata(cpu_wdata),
        .cpu_rd(cpu_rd), .cpu_rdata(cpu_rdata), .port_in(port_in),
        .port_out(port_out), .port_oe(port_oe), .stb_n(stb_n), .ack_n(ack_n),
        .ibf(ibf), .obf_n(obf_n), .intr(intr), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_cfg(input logic m, input logic d);
        cfg_mode = m; cfg_dir = d; cfg_wr = 1'b1;
        tick();
        cfg_wr = 1'b0;
    endtask

    task automatic set_inte(input logic v);
        inte_val = v; inte_wr = 1'b1;
        tick();
        inte_wr = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick();
        vectors++; if (port_oe !== 1'b0) begin miscompares++; $display("FAIL rst_oe got %b exp 0", port_oe); end
        vectors++; if (obf_n !== 1'b1) begin miscompares++; $display("FAIL rst_obf_n got %b exp 1", obf_n); end
        vectors++; if (ibf !== 1'b0) begin miscompares++; $display("FAIL rst_ibf got %b exp 0", ibf); end
        vectors++; if (intr !== 1'b0) begin miscompares++; $display("FAIL rst_intr got %b exp 0", intr); end
        vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL rst_overrun got %b exp 0", overrun); end
        vectors++; if (port_out !== 8'h00) begin miscompares++; $display("FAIL rst_port_out got %h exp 00", port_out); end
        vectors++; if (cpu_rdata !== 8'h00) begin miscompares++; $display("FAIL rst_rdata got %h exp 00", cpu_rdata); end
        // Default config is mode 0 input: a read samples the pads.
        port_in = 8'h99; cpu_rd = 1'b1;
        tick();
        cpu_rd = 1'b0;
        vectors++; if (cpu_rdata !== 8'h99) begin miscompares++; $display("FAIL rst_m0_in_rd got %h exp 99", cpu_rdata); end
        vectors++; if (port_oe !== 1'b0) begin miscompares++; $display("FAIL rst_oe_en got %b exp 0", port_oe); end
    endtask

    task automatic test_mode0_out();
        do_cfg(1'b0, 1'b0);
        cpu_wdata = 8'hA5; cpu_wr = 1'b1;
        tick();
        cpu_wr = 1'b0;
        vectors++; if (port_out !== 8'hA5) begin miscompares++; $display("FAIL m0_port_out got %h exp a5", port_out); end
        vectors++; if (port_oe !== 1'b1) begin miscompares++; $display("FAIL m0_oe got %b exp 1", port_oe); end
        vectors++; if (obf_n !== 1'b1 || intr !== 1'b0) begin miscompares++; $display("FAIL m0_hs got obf_n=%b intr=%b exp 1/0", obf_n, intr); end
        cpu_rd = 1'b1;
        tick();
        cpu_rd = 1'b0;
        vectors++; if (cpu_rdata !== 8'hA5) begin miscompares++; $display("FAIL m0_rdback got %h exp a5", cpu_rdata); end
        port_en = 1'b0;
        tick();
        vectors++; if (port_oe !== 1'b0) begin miscompares++; $display("FAIL m0_oe_dis got %b exp 0", port_oe); end
        cpu_wdata = 8'h3C; cpu_wr = 1'b1;
        tick();
        cpu_wr = 1'b0;
        vectors++; if (port_out !== 8'hA5) begin miscompares++; $display("FAIL m0_wr_dis got %h exp a5", port_out); end
        port_en = 1'b1;
        tick();
    endtask

    task automatic test_mode1_in();
        do_cfg(1'b1, 1'b1);
        set_inte(1'b1);
        port_in = 8'h5A; stb_n = 1'b0;
        tick();
        vectors++; if (ibf !== 1'b0) begin miscompares++; $display("FAIL m1i_ibf_early got %b exp 0", ibf); end
        tick();
        vectors++; if (ibf !== 1'b1) begin miscompares++; $display("FAIL m1i_ibf got %b exp 1", ibf); end
        tick();
        stb_n = 1'b1; port_in = 8'h00;
        tick();
        vectors++; if (intr !== 1'b0) begin miscompares++; $display("FAIL m1i_intr_early got %b exp 0", intr); end
        tick();
        vectors++; if (intr !== 1'b1) begin miscompares++; $display("FAIL m1i_intr got %b exp 1", intr); end
        cpu_rd = 1'b1;
        tick();
        cpu_rd = 1'b0;
        vectors++; if (cpu_rdata !== 8'h5A) begin miscompares++; $display("FAIL m1i_rdata got %h exp 5a", cpu_rdata); end
        vectors++; if (ibf !== 1'b0 || intr !== 1'b0) begin miscompares++; $display("FAIL m1i_clr got ibf=%b intr=%b exp 0/0", ibf, intr); end
        vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL m1i_no_ovr got %b exp 0", overrun); end
    endtask

    task automatic test_overrun();
        port_in = 8'h11; stb_n = 1'b0; tick(2);
        stb_n = 1'b1; tick(2);
        port_in = 8'h77; stb_n = 1'b0; tick(2);
        vectors++; if (overrun !== 1'b1) begin miscompares++; $display("FAIL ovr_in got %b exp 1", overrun); end
        stb_n = 1'b1; tick(2);
        cpu_rd = 1'b1;
        tick();
        cpu_rd = 1'b0;
        vectors++; if (cpu_rdata !== 8'h77) begin miscompares++; $display("FAIL ovr_rdata got %h exp 77", cpu_rdata); end
        vectors++; if (ibf !== 1'b0) begin miscompares++; $display("FAIL ovr_ibf got %b exp 0", ibf); end
        // Fill once, then let the next strobe's fall coincide with a read.
        port_in = 8'h22; stb_n = 1'b0; tick(2);
        stb_n = 1'b1; tick(2);
        port_in = 8'h33; stb_n = 1'b0; tick();
        cpu_rd = 1'b1;
        tick();
        cpu_rd = 1'b0;
        vectors++; if (ibf !== 1'b1) begin miscompares++; $display("FAIL coin_ibf got %b exp 1", ibf); end
        vectors++; if (cpu_rdata !== 8'h22) begin miscompares++; $display("FAIL coin_rdata got %h exp 22", cpu_rdata); end
        vectors++; if (intr !== 1'b0) begin miscompares++; $display("FAIL coin_intr got %b exp 0", intr); end
        stb_n = 1'b1; tick(2);
        cpu_rd = 1'b1;
        tick();
        cpu_rd = 1'b0;
        vectors++; if (cpu_rdata !== 8'h33) begin miscompares++; $display("FAIL coin_new_data got %h exp 33", cpu_rdata); end
    endtask

    task automatic test_mode1_out();
        do_cfg(1'b1, 1'b0);
        vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL m1o_cfg_ovr got %b exp 0", overrun); end
        set_inte(1'b1);
        cpu_wdata = 8'hC3; cpu_wr = 1'b1;
        tick();
        cpu_wr = 1'b0;
        vectors++; if (obf_n !== 1'b0) begin miscompares++; $display("FAIL m1o_obf got %b exp 0", obf_n); end
        vectors++; if (port_out !== 8'hC3 || port_oe !== 1'b1) begin miscompares++; $display("FAIL m1o_out got %h/%b exp c3/1", port_out, port_oe); end
        ack_n = 1'b0; tick();
        vectors++; if (obf_n !== 1'b0) begin miscompares++; $display("FAIL m1o_obf_early got %b exp 0", obf_n); end
        tick();
        vectors++; if (obf_n !== 1'b1) begin miscompares++; $display("FAIL m1o_ack got %b exp 1", obf_n); end
        ack_n = 1'b1; tick(2);
        vectors++; if (intr !== 1'b1) begin miscompares++; $display("FAIL m1o_intr got %b exp 1", intr); end
        cpu_wdata = 8'h44; cpu_wr = 1'b1;
        tick();
        cpu_wr = 1'b0;
        vectors++; if (intr !== 1'b0 || obf_n !== 1'b0) begin miscompares++; $display("FAIL m1o_wr_clr got intr=%b obf_n=%b exp 0/0", intr, obf_n); end
        cpu_wdata = 8'h55; cpu_wr = 1'b1;
        tick();
        cpu_wr = 1'b0;
        vectors++; if (overrun !== 1'b1 || port_out !== 8'h55) begin miscompares++; $display("FAIL m1o_ovr got %b/%h exp 1/55", overrun, port_out); end
        // Write lands in the same cycle the ack rising edge is seen.
        ack_n = 1'b0; tick(2);
        ack_n = 1'b1; tick();
        cpu_wdata = 8'h66; cpu_wr = 1'b1;
        tick();
        cpu_wr = 1'b0;
        vectors++; if (obf_n !== 1'b0 || intr !== 1'b0 || port_out !== 8'h66) begin miscompares++; $display("FAIL m1o_coin got obf_n=%b intr=%b out=%h exp 0/0/66", obf_n, intr, port_out); end
        cpu_rd = 1'b1;
        tick();
        cpu_rd = 1'b0;
        vectors++; if (cpu_rdata !== 8'h66) begin miscompares++; $display("FAIL m1o_rdback got %h exp 66", cpu_rdata); end
    endtask

    task automatic test_cfg_change();
        do_cfg(1'b1, 1'b1);
        vectors++; if (port_out !== 8'h00 || obf_n !== 1'b1) begin miscompares++; $display("FAIL cfg_clr got out=%h obf_n=%b exp 00/1", port_out, obf_n); end
        vectors++; if (intr !== 1'b0 || port_oe !== 1'b0 || overrun !== 1'b0) begin miscompares++; $display("FAIL cfg_flags got intr=%b oe=%b ovr=%b exp 0/0/0", intr, port_oe, overrun); end
        // inte was cleared: a full strobe must not raise intr.
        port_in = 8'hE1; stb_n = 1'b0; tick(2);
        stb_n = 1'b1; tick(2);
        vectors++; if (ibf !== 1'b1 || intr !== 1'b0) begin miscompares++; $display("FAIL cfg_inte got ibf=%b intr=%b exp 1/0", ibf, intr); end
    endtask

    task automatic test_reset_mid();
        port_in = 8'hB2; stb_n = 1'b0; tick(2);
        reset = 1'b1;
        tick();
        reset = 1'b0; stb_n = 1'b1;
        vectors++; if (ibf !== 1'b0 || intr !== 1'b0 || overrun !== 1'b0) begin miscompares++; $display("FAIL rstmid_flags got ibf=%b intr=%b ovr=%b exp 0/0/0", ibf, intr, overrun); end
        vectors++; if (obf_n !== 1'b1 || port_oe !== 1'b0 || cpu_rdata !== 8'h00) begin miscompares++; $display("FAIL rstmid_out got obf_n=%b oe=%b rd=%h exp 1/0/00", obf_n, port_oe, cpu_rdata); end
    endtask

    initial begin
        reset = 1'b1; port_en = 1'b1; cfg_wr = 1'b0; cfg_mode = 1'b0; cfg_dir = 1'b1;
        inte_wr = 1'b0; inte_val = 1'b0; cpu_wr = 1'b0; cpu_rd = 1'b0;
        cpu_wdata = 8'h00; port_in = 8'h00; stb_n = 1'b1; ack_n = 1'b1;
        test_reset();
        test_mode0_out();
        test_mode1_in();
        test_overrun();
        test_mode1_out();
        test_cfg_change();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
